// File: rtl/axi3_pkg.sv
// Shared AXI3 types, response codes and the per-beat burst address helper
// used by the SRAM slave.
package axi3_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RD      = 2'b01,
    ST_WR_DATA = 2'b10,
    ST_WR_RESP = 2'b11
  } state_e;

  localparam logic [1:0] AXI_OKAY   = RESP_OKAY;
  localparam logic [1:0] AXI_SLVERR = RESP_SLVERR;

  // Address of the following beat; WRAP wraps inside a (beats << size)-byte aligned window.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [1:0] burst, input logic [3:0] len);
    logic [31:0] step;
    logic [31:0] mask;
    logic [31:0] res;
    step = 32'd1 << size;
    mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
    case (burst_e'(burst))
      BURST_FIXED: res = addr;
      BURST_WRAP:  res = (addr & ~mask) | ((addr + step) & mask);
      default:     res = addr + step;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sram_bytewise.sv
// Single-port 32-bit word array with a registered synchronous read and a
// byte-enabled write; the array itself is never reset.
module sram_bytewise #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wstrb,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register; re-reading the same address keeps the word stable
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= 32'd0;
    end else if (en && !we) begin
      rdata <= mem_r[addr];
    end
  end

endmodule

// File: rtl/axi3_sram_slave.sv
// AXI3 slave over a single-port SRAM, one transaction outstanding.
// Define AXI3_SRAM_WRAP_EN to accept WRAP bursts of 2/4/8/16 beats.
module axi3_sram_slave
  import axi3_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);
`ifdef AXI3_SRAM_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  function automatic logic beat_oob(input logic [31:0] a);
    return ((a - BASE_ADDR) >> 2) >= DEPTH_W;
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [3:0] len);
    logic wrap_ok;
    wrap_ok = WRAP_EN && ((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
    return (size > 3'd2) || (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_ok);
  endfunction

  state_e      state_r, state_nxt_s;
  logic        rr_rd_r;
  logic [31:0] addr_r, rd_nxt_s, mem_byte_s, mem_q_s;
  logic [3:0]  cnt_r, len_r, rid_r, bid_r;
  logic [2:0]  size_r;
  logic [1:0]  burst_r, rresp_r, bresp_r;
  logic        bad_r, rvalid_r, rlast_r, rerr_r, bvalid_r, werr_r;
  logic        ar_bad_s, aw_bad_s, wbeat_err_s, mem_en_s, mem_we_s, unused_s;

  assign ar_bad_s    = burst_bad(arsize, arburst, arlen[3:0]);
  assign aw_bad_s    = burst_bad(awsize, awburst, awlen[3:0]);
  assign rd_nxt_s    = next_addr(addr_r, size_r, burst_r, len_r);
  assign wbeat_err_s = bad_r || beat_oob(addr_r) || (wlast != (cnt_r == 4'd0));
  assign unused_s    = ^{arlock, arcache, arprot, arlen[7:4], awlock, awcache, awprot, awlen[7:4], wid};

  assign rid    = rid_r;
  assign rresp  = rresp_r;
  assign rlast  = rlast_r;
  assign rvalid = rvalid_r;
  assign rdata  = rerr_r ? 32'd0 : mem_q_s;
  assign bid    = bid_r;
  assign bresp  = bresp_r;
  assign bvalid = bvalid_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (arvalid && arready)      state_nxt_s = ST_RD;
        else if (awvalid && awready) state_nxt_s = ST_WR_DATA;
        else                         state_nxt_s = ST_IDLE;
      end
      ST_RD: begin
        if (rvalid_r && rready && rlast_r) state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_RD;
      end
      ST_WR_DATA: begin
        if (wvalid && wlast) state_nxt_s = ST_WR_RESP;
        else                 state_nxt_s = ST_WR_DATA;
      end
      ST_WR_RESP: begin
        if (bready) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_WR_RESP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: channel readies and the SRAM port
  always_comb begin
    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    mem_byte_s = addr_r;
    mem_en_s   = 1'b0;
    mem_we_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        arready    = !rst && (rr_rd_r || !awvalid);
        awready    = !rst && (!rr_rd_r || !arvalid);
        mem_byte_s = araddr;
        mem_en_s   = arvalid && arready && !ar_bad_s && !beat_oob(araddr);
      end
      ST_RD: begin
        // Fetch the next beat on acceptance, otherwise refresh the held one
        if (rvalid_r && rready && !rlast_r) mem_byte_s = rd_nxt_s;
        else                                mem_byte_s = addr_r;
        mem_en_s = !bad_r && !beat_oob(mem_byte_s);
      end
      ST_WR_DATA: begin
        wready     = !rst;
        mem_byte_s = addr_r;
        mem_en_s   = wvalid && !rst && !bad_r && !beat_oob(addr_r);
        mem_we_s   = mem_en_s;
      end
      ST_WR_RESP: begin
        mem_en_s = 1'b0;
      end
      default: begin
        mem_en_s = 1'b0;
      end
    endcase
  end

  // Burst bookkeeping and registered R/B channel outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_rd_r  <= 1'b1;
      addr_r   <= 32'd0;
      cnt_r    <= 4'd0;
      len_r    <= 4'd0;
      size_r   <= 3'd0;
      burst_r  <= 2'd0;
      bad_r    <= 1'b0;
      rid_r    <= 4'd0;
      rvalid_r <= 1'b0;
      rlast_r  <= 1'b0;
      rresp_r  <= AXI_OKAY;
      rerr_r   <= 1'b0;
      bid_r    <= 4'd0;
      bvalid_r <= 1'b0;
      bresp_r  <= AXI_OKAY;
      werr_r   <= 1'b0;
    end else if (arvalid && arready) begin
      rr_rd_r  <= 1'b0;
      addr_r   <= araddr;
      cnt_r    <= arlen[3:0];
      len_r    <= arlen[3:0];
      size_r   <= arsize;
      burst_r  <= arburst;
      bad_r    <= ar_bad_s;
      rid_r    <= arid;
      rvalid_r <= 1'b1;
      rlast_r  <= (arlen[3:0] == 4'd0);
      rerr_r   <= ar_bad_s || beat_oob(araddr);
      rresp_r  <= (ar_bad_s || beat_oob(araddr)) ? AXI_SLVERR : AXI_OKAY;
    end else if (awvalid && awready) begin
      rr_rd_r <= 1'b1;
      addr_r  <= awaddr;
      cnt_r   <= awlen[3:0];
      len_r   <= awlen[3:0];
      size_r  <= awsize;
      burst_r <= awburst;
      bad_r   <= aw_bad_s;
      bid_r   <= awid;
      werr_r  <= 1'b0;
    end else if (state_r == ST_RD && rvalid_r && rready) begin
      if (rlast_r) begin
        rvalid_r <= 1'b0;
      end else begin
        addr_r  <= rd_nxt_s;
        cnt_r   <= cnt_r - 4'd1;
        rlast_r <= (cnt_r == 4'd1);
        rerr_r  <= bad_r || beat_oob(rd_nxt_s);
        rresp_r <= (bad_r || beat_oob(rd_nxt_s)) ? AXI_SLVERR : AXI_OKAY;
      end
    end else if (state_r == ST_WR_DATA && wvalid) begin
      addr_r <= rd_nxt_s;
      cnt_r  <= (cnt_r == 4'd0) ? 4'd0 : cnt_r - 4'd1;
      werr_r <= werr_r || wbeat_err_s;
      if (wlast) begin
        bvalid_r <= 1'b1;
        bresp_r  <= (werr_r || wbeat_err_s) ? AXI_SLVERR : AXI_OKAY;
      end
    end else if (state_r == ST_WR_RESP && bready) begin
      bvalid_r <= 1'b0;
    end
  end

  sram_bytewise #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en_s),
    .we    (mem_we_s),
    .addr  (word_idx(mem_byte_s)),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (mem_q_s)
  );

endmodule

// File: tb/tb_axi3_sram_slave.sv
// Directed bench for axi3_sram_slave: reset, arbitration, INCR/FIXED/WRAP
// bursts, strobes, R back-pressure, error responses and mid-burst reset.
module tb_axi3_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int passed = 0;
  int total  = 0;

  axi3_sram_slave dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    check("arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic aw_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    check("awready", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    #1;
    n = 0;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    check("wready", {31'd0, wready}, 32'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_get(input logic [3:0] id, input logic [1:0] resp);
    int n;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    check("bvalid", {31'd0, bvalid}, 32'd1);
    check("bid", {28'd0, bid}, {28'd0, id});
    check("bresp", {30'd0, bresp}, {30'd0, resp});
    @(negedge clk);
    bready = 1'b0;
    check("bvalid_drop", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic r_get(input string tag, input logic [3:0] id, input logic [31:0] data,
                       input logic [1:0] resp, input logic last, input logic chk_data);
    int n;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_rid"}, {28'd0, rid}, {28'd0, id});
    check({tag, "_rresp"}, {30'd0, rresp}, {30'd0, resp});
    check({tag, "_rlast"}, {31'd0, rlast}, {31'd0, last});
    if (chk_data) check({tag, "_rdata"}, rdata, data);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rready = 1'b0; bready = 1'b0;
    arvalid = 1'b0; arid = 4'd0; araddr = 32'd0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01;
    arlock = 2'd0; arcache = 4'd0; arprot = 3'd0;
    awvalid = 1'b0; awid = 4'd0; awaddr = 32'd0; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01;
    awlock = 2'd0; awcache = 4'd0; awprot = 3'd0;
    wvalid = 1'b0; wid = 4'd0; wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_bvalid", {31'd0, bvalid}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_wready", {31'd0, wready}, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    // Simultaneous AR and AW out of reset: read first
    rst = 1'b0; rready = 1'b1;
    arid = 4'd5; araddr = 32'h0; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = 4'd6; awaddr = 32'h4; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    #1;
    check("arb_arready", {31'd0, arready}, 32'd1);
    check("arb_awready", {31'd0, awready}, 32'd0);
    @(negedge clk);
    arvalid = 1'b0;
    check("arb_rvalid", {31'd0, rvalid}, 32'd1);
    r_get("arb_rd", 4'd5, 32'd0, 2'b00, 1'b1, 1'b0);
    check("arb_awready2", {31'd0, awready}, 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    w_beat(32'h1122_3344, 4'hF, 1'b1);
    b_get(4'd6, 2'b00);

    // Fill words 0x10..0x13 then INCR read back
    aw_req(4'd1, 32'h40, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h1000_0010 + 32'(i), 4'hF, (i == 3));
    b_get(4'd1, 2'b00);
    ar_req(4'd3, 32'h40, 8'd3, 3'd2, 2'b01);
    check("incr_first_cycle", {31'd0, rvalid}, 32'd1);
    for (int i = 0; i < 4; i++) r_get("incr", 4'd3, 32'h1000_0010 + 32'(i), 2'b00, (i == 3), 1'b1);
    check("incr_done", {31'd0, rvalid}, 32'd0);

    // Strobed write over a known word
    aw_req(4'd2, 32'h8, 8'd0, 3'd2, 2'b01);
    w_beat(32'h0102_0304, 4'hF, 1'b1);
    b_get(4'd2, 2'b00);
    aw_req(4'd2, 32'h8, 8'd0, 3'd2, 2'b01);
    w_beat(32'hAABB_CCDD, 4'b0101, 1'b1);
    b_get(4'd2, 2'b00);
    ar_req(4'd4, 32'h8, 8'd0, 3'd2, 2'b01);
    r_get("strb", 4'd4, 32'h01BB_03DD, 2'b00, 1'b1, 1'b1);

    // rready low for three cycles on beat 2
    ar_req(4'd8, 32'h40, 8'd3, 3'd2, 2'b01);
    r_get("stall0", 4'd8, 32'h1000_0010, 2'b00, 1'b0, 1'b1);
    rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_rvalid", {31'd0, rvalid}, 32'd1);
      check("stall_rdata", rdata, 32'h1000_0011);
      check("stall_rlast", {31'd0, rlast}, 32'd0);
      check("stall_rid", {28'd0, rid}, 32'd8);
      @(negedge clk);
    end
    rready = 1'b1;
    for (int i = 1; i < 4; i++) r_get("stall", 4'd8, 32'h1000_0010 + 32'(i), 2'b00, (i == 3), 1'b1);

    // Out-of-range read at DEPTH_WORDS*4
    ar_req(4'd9, 32'h1000, 8'd1, 3'd2, 2'b01);
    r_get("oob0", 4'd9, 32'd0, 2'b10, 1'b0, 1'b1);
    r_get("oob1", 4'd9, 32'd0, 2'b10, 1'b1, 1'b1);

    // Oversized beat
    ar_req(4'd10, 32'h40, 8'd0, 3'd3, 2'b01);
    r_get("size3", 4'd10, 32'd0, 2'b10, 1'b1, 1'b1);

    // FIXED burst with len[7:4] set: two beats at the same word
    ar_req(4'd12, 32'h40, 8'h11, 3'd2, 2'b00);
    r_get("fixed0", 4'd12, 32'h1000_0010, 2'b00, 1'b0, 1'b1);
    r_get("fixed1", 4'd12, 32'h1000_0010, 2'b00, 1'b1, 1'b1);
    check("fixed_done", {31'd0, rvalid}, 32'd0);

    // awlen 3 with wlast on beat 2: SLVERR, beats still written
    aw_req(4'd7, 32'h50, 8'd3, 3'd2, 2'b01);
    w_beat(32'h3000_0050, 4'hF, 1'b0);
    w_beat(32'h3000_0054, 4'hF, 1'b1);
    b_get(4'd7, 2'b10);
    ar_req(4'd7, 32'h50, 8'd1, 3'd2, 2'b01);
    r_get("early0", 4'd7, 32'h3000_0050, 2'b00, 1'b0, 1'b1);
    r_get("early1", 4'd7, 32'h3000_0054, 2'b00, 1'b1, 1'b1);

    // WRAP read from 0x38 over words 0xC..0xF
    aw_req(4'd11, 32'h30, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_beat(32'h2000_000C + 32'(i), 4'hF, (i == 3));
    b_get(4'd11, 2'b00);
    ar_req(4'd13, 32'h38, 8'd3, 3'd2, 2'b10);
`ifdef AXI3_SRAM_WRAP_EN
    r_get("wrap0", 4'd13, 32'h2000_000E, 2'b00, 1'b0, 1'b1);
    r_get("wrap1", 4'd13, 32'h2000_000F, 2'b00, 1'b0, 1'b1);
    r_get("wrap2", 4'd13, 32'h2000_000C, 2'b00, 1'b0, 1'b1);
    r_get("wrap3", 4'd13, 32'h2000_000D, 2'b00, 1'b1, 1'b1);
`else
    for (int i = 0; i < 4; i++) r_get("wrap_err", 4'd13, 32'd0, 2'b10, (i == 3), 1'b1);
`endif

    // Reset mid-burst: burst dropped, array retained
    ar_req(4'd14, 32'h40, 8'd3, 3'd2, 2'b01);
    r_get("mid0", 4'd14, 32'h1000_0010, 2'b00, 1'b0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_arready", {31'd0, arready}, 32'd1);
    @(negedge clk);
    check("mid_rvalid2", {31'd0, rvalid}, 32'd0);
    ar_req(4'd15, 32'h44, 8'd0, 3'd2, 2'b01);
    r_get("retain", 4'd15, 32'h1000_0011, 2'b00, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi3_sram_slave.md
AXI3_SRAM_SLAVE -- requirements
Module: axi3_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the array.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of word 0.
REQ-003 SHALL have ports `clk`, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port `rst`, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have the AR channel ports `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arlock`, `arcache`, `arprot` and `arvalid` as inputs, and `arready` as output.
REQ-006 SHALL have the R channel ports `rid[3:0]`, `rdata[31:0]`, `rresp[1:0]`, `rlast` and `rvalid` as outputs, and `rready` as input.
REQ-007 SHALL have the AW channel ports `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot` and `awvalid` as inputs, and `awready` as output.
REQ-008 SHALL have the W channel ports `wid`, `wdata`, `wstrb`, `wlast` and `wvalid` as inputs, and `wready` as output.
REQ-009 SHALL have the B channel ports `bid[3:0]`, `bresp[1:0]` and `bvalid` as outputs, and `bready` as input.
REQ-010 SHALL give all AXI3 ports the AXI3 widths: IDs 4, address 32, len 8, size 3, burst 2, lock 2, cache 4, prot 3.

Function
REQ-011 SHALL have a main FSM with the states IDLE, RD, WR_DATA and WR_RESP, and SHALL keep at most one transaction outstanding.
REQ-012 SHALL assert `arready`/`awready` only in IDLE; if both valids are high, a round-robin pointer SHALL pick the channel, and after reset reads SHALL win.
REQ-013 SHALL use only `len[3:0]` as the beat count (beats = len[3:0]+1, at most 16); `len[7:4]` SHALL be ignored.
REQ-014 SHALL handle a FIXED burst by holding the address and an INCR burst by adding 1<<size per beat.
REQ-015 SHALL respond to every beat of a burst with `size` greater than 2, or with `burst` equal to 2'b11, with SLVERR.
REQ-016 SHALL give SLVERR to a beat whose word index is at or above DEPTH_WORDS (address below BASE_ADDR wraps as unsigned); such a beat SHALL return `rdata` 0 and SHALL NOT write the array.
REQ-017 SHALL raise `rvalid` in the first cycle after the AR handshake, and SHALL sustain one beat per cycle while `rready` is high.
REQ-018 SHALL hold `rdata`, `rresp`, `rlast` and `rid` stable while `rvalid` is high and `rready` is low.
REQ-019 SHALL return `rid` equal to `arid`, and SHALL assert `rlast` only on the final beat, after which the FSM returns to IDLE.
REQ-020 SHALL hold `wready` high in WR_DATA, and SHALL write each accepted beat with byte enables `wstrb`.
REQ-021 SHALL flag an error, without aborting, when `wlast` arrives before or after the expected beat; it SHALL stay in WR_DATA until `wlast` is accepted.
REQ-022 SHALL drive B in WR_RESP with `bvalid` high and `bid` equal to `awid`; `bresp` SHALL be SLVERR if any beat erred or `wlast` was misplaced, else OKAY.
REQ-023 SHALL hold the B response until `bready` is high, then return to IDLE.
REQ-024 SHALL leave `wid` unchecked.
REQ-025 SHALL drive `rresp`/`bresp` only as OKAY (2'b00) or SLVERR (2'b10).

Reset
REQ-026 SHALL, on reset, set the FSM to IDLE, the round-robin pointer to read-first, and all outputs to 0.
REQ-027 SHALL, on reset mid-burst, abort the burst and issue no response; array contents SHALL be retained.

Configuration
REQ-028 SHALL, when AXI3_SRAM_WRAP_EN is defined, accept WRAP bursts (2'b10) that have len[3:0] of 1, 3, 7 or 15, wrapping at the (beats<<size)-byte aligned boundary.
REQ-029 SHALL, when AXI3_SRAM_WRAP_EN is undefined, give SLVERR to every beat of a WRAP burst, with no array writes.

Structure
REQ-030 SHALL place the burst type, response code and FSM state enums, and the OKAY/SLVERR constants, in the shared package axi3_pkg.
REQ-031 SHALL instantiate one sub-module, sram_bytewise: a single-port array with a synchronous read and a byte-enabled write.

Verification
REQ-032 SHALL test INCR read: araddr 0x40, arlen 3, size 2 -> four beats from words 0x10 to 0x13, rlast on beat 4, rresp OKAY, rid echoed.
REQ-033 SHALL test a strobed write: awaddr 0x8, 1 beat, wdata 0xAABBCCDD, wstrb 4'b0101 -> only bytes 0 and 2 change; bresp OKAY.
REQ-034 SHALL test simultaneous AR and AW out of reset -> read served first, then write.
REQ-035 SHALL test rready low for 3 cycles mid-burst -> R signals stable, no beat lost.
REQ-036 SHALL test out-of-range or misplaced-wlast bursts: araddr at DEPTH_WORDS*4 -> SLVERR, rdata 0; awlen 3 with wlast on beat 2 -> bresp SLVERR after wlast.
REQ-037 SHALL test WRAP: araddr 0x38, len 3 -> words 0xE, 0xF, 0xC, 0xD with the macro, and four SLVERR beats without it.
